serial_word_assembler: RTL and testbench
========================================

Name: serial_word_assembler

Overview:
- Downstream consumer of the enabled D flip-flop's serial output.
- Collects bits presented on D, one bit per cycle in which the enable strobe E is high.
- Frames every WIDTH bits into a parallel word and holds it in a one-deep output slot under a Valid/Ready handshake.
- Flags lost words with a sticky overrun bit. Used wherever a strobed bit stream must become bytes or words.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in Q[WIDTH-1]; 0 = first received bit lands in Q[0].

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- E  input  1  bit strobe; D is sampled on a rising edge only when E=1.
- D  input  1  serial data bit (normally the flip-flop's Q).
- Clear  input  1  synchronous frame restart; discards the partial word and clears Overrun.
- Ready  input  1  consumer accepts Q on a rising edge when Valid=1 and Ready=1.
- Q  output  WIDTH  assembled word (output slot).
- Valid  output  1  output slot holds an unconsumed word.
- Overrun  output  1  sticky; a completed word was dropped.
- BitCount  output  $clog2(WIDTH+1)  bits collected in the current partial word, 0..WIDTH-1.

Behaviour:
- Reset (async, any time, including mid-word): shift register=0, BitCount=0, Q=0, Valid=0, Overrun=0. Outputs change immediately on assertion, not at the next edge.
- Internal storage: shift register SR[WIDTH-1:0] plus separate output register Q (double buffered). Collection continues while Q is held.
- Shift on edge with E=1 and Clear=0:
  - MSB_FIRST=1: SR <= {SR[WIDTH-2:0], D}.
  - MSB_FIRST=0: SR <= {D, SR[WIDTH-1:1]}.
  - BitCount increments.
- Word completion: edge with E=1, Clear=0 and BitCount==WIDTH-1.
  - The word formed including this D is the "new word". BitCount <= 0 and SR <= 0.
  - If Valid=0, or Valid=1 and Ready=1 on this same edge: Q <= new word, Valid <= 1. Latency: Valid rises at the same edge that samples the last bit.
  - Otherwise the new word is discarded, Q is unchanged and Overrun <= 1.
- Consumption: edge with Valid=1, Ready=1 and no word completion: Valid <= 0. Q keeps its value, which is don't-care to the consumer.
- Ready while Valid=0 has no effect.
- E=0: SR and BitCount hold. D is ignored.
- Clear=1 on an edge: SR <= 0, BitCount <= 0, Overrun <= 0. Clear has priority over E, so no bit is sampled that cycle.
  - Clear does not touch Q or Valid; a held word survives Clear.
  - Handshake consumption on the same edge still occurs.
- Overrun stays 1 until Clear or Reset. Further drops keep it at 1.
- BitCount never reaches WIDTH; its wrap point is WIDTH-1 -> 0.
- No combinational path from any input to any output. All outputs are registers.
- States (implicit, derived from Valid): EMPTY (Valid=0) and FULL (Valid=1).
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on consumption with no completion.
  - FULL -> FULL on completion with Ready=1 (word replaced), or on completion with Ready=0 (drop, Overrun).

Test Plan:
- Reset mid-operation: WIDTH=8, MSB_FIRST=1. Shift 3 bits, then assert Reset between clock edges -> Q=0, Valid=0, Overrun=0, BitCount=0 immediately. Resume and shift 8 bits -> a full fresh word with no leftover bits.
- Basic MSB-first: WIDTH=8, MSB_FIRST=1, Ready=0. Strobe D=1,0,1,0,0,1,0,1 on 8 consecutive E cycles -> Valid=1 after the 8th edge, Q=8'hA5, BitCount=0. Then Ready=1 for one edge -> Valid=0.
- LSB-first with gaps: MSB_FIRST=0. Same bit sequence with E=0 idle cycles interleaved, where D toggles while E=0 -> Q=8'hA5 reversed = 8'hA5 (palindrome check). Repeat with bits 1,0,0,0,0,0,0,0 -> Q=8'h01. BitCount holds during E=0.
- Back-to-back with same-edge pop: Valid=1, Q=8'h11. Complete the next word 8'h22 on an edge where Ready=1 -> Q=8'h22, Valid stays 1, Overrun=0.
- Overrun: Valid=1, Q=8'h11, Ready=0. Complete word 8'h33 -> Q stays 8'h11 and Overrun=1. Then Ready=1 -> Valid=0 and Overrun stays 1. Then Clear=1 -> Overrun=0.
- Clear mid-word: after 5 bits, pulse Clear with E=1 and D=1 on the same edge -> BitCount=0, that bit is not sampled, and a held Q/Valid is unchanged. The next 8 strobed bits form an exact word.

Source files
------------

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: strobed bits are shifted into a staging register
// and framed every WIDTH bits into a double-buffered output slot with a Valid/Ready handshake.
module serial_word_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       E,
    input  logic                       D,
    input  logic                       Clear,
    input  logic                       Ready,
    output logic [WIDTH-1:0]           Q,
    output logic                       Valid,
    output logic                       Overrun,
    output logic [$clog2(WIDTH+1)-1:0] BitCount
);

    localparam int             CW   = $clog2(WIDTH+1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH-1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    logic             shift;
    logic             complete;
    logic             accept;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sr[WIDTH-2:0], D};
        end else begin : g_lsb
            assign shifted = {D, sr[WIDTH-1:1]};
        end
    endgenerate

    // Clear wins over the strobe, so a cleared edge never samples D.
    assign shift    = E & ~Clear;
    assign complete = shift & (BitCount == LAST);
    assign accept   = (state == EMPTY) | Ready;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (complete)           state_next = FULL;
            FULL:  if (!complete && Ready) state_next = EMPTY;
            default:                       state_next = EMPTY;
        endcase
    end

    assign Valid = (state == FULL);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sr       <= '0;
            BitCount <= '0;
            Q        <= '0;
            Overrun  <= 1'b0;
        end else if (Clear) begin
            sr       <= '0;
            BitCount <= '0;
            Overrun  <= 1'b0;
        end else if (complete) begin
            sr       <= '0;
            BitCount <= '0;
            // A full slot not being drained this edge means the new word is lost.
            if (accept) Q       <= shifted;
            else        Overrun <= 1'b1;
        end else if (shift) begin
            sr       <= shifted;
            BitCount <= BitCount + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: MSB-first and LSB-first instances share stimulus and
// are checked against a queue-based word model, a vector table and directed sequences.
module tb_serial_word_assembler;

    localparam int W = 8;

    logic       Clock, Reset, E, D, Clear, Ready;
    logic [7:0] q_m, q_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;
    logic [3:0] cnt_m, cnt_l;

    serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .Clock(Clock), .Reset(Reset), .E(E), .D(D), .Clear(Clear), .Ready(Ready),
        .Q(q_m), .Valid(valid_m), .Overrun(ovr_m), .BitCount(cnt_m));

    serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .Clock(Clock), .Reset(Reset), .E(E), .D(D), .Clear(Clear), .Ready(Ready),
        .Q(q_l), .Valid(valid_l), .Overrun(ovr_l), .BitCount(cnt_l));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: received bits of the partial word kept in arrival order.
    bit      m_bits[$];
    int      m_q_msb, m_q_lsb;
    bit      m_valid, m_ovr;

    task automatic cmp(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input bit msb_first);
        int w = 0;
        for (int i = 0; i < m_bits.size(); i++)
            if (m_bits[i]) w += msb_first ? (1 << (W-1-i)) : (1 << i);
        return w;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_q_msb = 0;
        m_q_lsb = 0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    task automatic model_edge(input bit e, input bit d, input bit clr, input bit rdy);
        bit pop;
        pop = m_valid && rdy;
        if (clr) begin
            m_bits.delete();
            m_ovr = 0;
            if (pop) m_valid = 0;
        end else if (e && m_bits.size() == W-1) begin
            m_bits.push_back(d);
            if (!m_valid || rdy) begin
                m_q_msb = word_of(1);
                m_q_lsb = word_of(0);
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
            m_bits.delete();
        end else begin
            if (e) m_bits.push_back(d);
            if (pop) m_valid = 0;
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".q_msb"},   int'(q_m),     m_q_msb);
        cmp({tag, ".q_lsb"},   int'(q_l),     m_q_lsb);
        cmp({tag, ".valid_m"}, int'(valid_m), int'(m_valid));
        cmp({tag, ".valid_l"}, int'(valid_l), int'(m_valid));
        cmp({tag, ".ovr_m"},   int'(ovr_m),   int'(m_ovr));
        cmp({tag, ".ovr_l"},   int'(ovr_l),   int'(m_ovr));
        cmp({tag, ".cnt_m"},   int'(cnt_m),   m_bits.size());
        cmp({tag, ".cnt_l"},   int'(cnt_l),   m_bits.size());
    endtask

    task automatic step(input string tag, input bit e, input bit d, input bit clr, input bit rdy);
        E = e; D = d; Clear = clr; Ready = rdy;
        @(posedge Clock);
        model_edge(e, d, clr, rdy);
        #1;
        check_model(tag);
    endtask

    // Strobes w MSB-first onto the wire on 8 consecutive edges; Ready only on the last.
    task automatic send_word(input string tag, input logic [7:0] w, input bit rdy_last);
        for (int i = 0; i < 8; i++)
            step(tag, 1'b1, w[7-i], 1'b0, (i == 7) ? rdy_last : 1'b0);
    endtask

    task automatic send_gapped(input string tag, input logic [7:0] w);
        logic [3:0] held;
        for (int i = 0; i < 8; i++) begin
            step(tag, 1'b1, w[7-i], 1'b0, 1'b0);
            held = cnt_m;
            step(tag, 1'b0, ~w[7-i], 1'b0, 1'b0);
            step(tag, 1'b0, w[7-i], 1'b0, 1'b0);
            cmp({tag, ".cnt_hold"}, int'(cnt_m), int'(held));
        end
    endtask

    typedef struct {
        logic       e, d, clr, rdy;
        logic [7:0] q_msb, q_lsb;
        logic       valid, ovr;
        int         cnt;
    } vec_t;

    vec_t vt[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        bit         r_e, r_d, r_c, r_r;

        pat = 8'hA5;
        for (int i = 0; i < 8; i++)
            vt[i] = '{1'b1, pat[7-i], 1'b0, 1'b0,
                      (i == 7) ? 8'hA5 : 8'h00, (i == 7) ? 8'hA5 : 8'h00,
                      (i == 7), 1'b0, (i + 1) % 8};
        vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 0};

        E = 0; D = 0; Clear = 0; Ready = 0;
        Reset = 1;
        model_reset();
        #1;
        cmp("reset.q",     int'(q_m),     0);
        cmp("reset.valid", int'(valid_m), 0);
        cmp("reset.ovr",   int'(ovr_m),   0);
        cmp("reset.cnt",   int'(cnt_m),   0);
        repeat (2) @(posedge Clock);
        #3 Reset = 0;

        // Basic MSB-first A5 (palindrome, so LSB-first gives A5 too), then pop.
        for (int i = 0; i < 9; i++) begin
            step("table", vt[i].e, vt[i].d, vt[i].clr, vt[i].rdy);
            cmp("table.q_msb", int'(q_m),     int'(vt[i].q_msb));
            cmp("table.q_lsb", int'(q_l),     int'(vt[i].q_lsb));
            cmp("table.valid", int'(valid_m), int'(vt[i].valid));
            cmp("table.ovr",   int'(ovr_m),   int'(vt[i].ovr));
            cmp("table.cnt",   int'(cnt_m),   vt[i].cnt);
        end

        // Asynchronous reset mid-word, then a clean word.
        step("rst", 1, 1, 0, 0);
        step("rst", 1, 1, 0, 0);
        step("rst", 1, 0, 0, 0);
        #3 Reset = 1;
        model_reset();
        #1;
        cmp("rst_mid.q",     int'(q_m),     0);
        cmp("rst_mid.valid", int'(valid_m), 0);
        cmp("rst_mid.ovr",   int'(ovr_m),   0);
        cmp("rst_mid.cnt",   int'(cnt_m),   0);
        #2 Reset = 0;
        send_word("rst_resume", 8'h3C, 1'b0);
        cmp("rst_resume.q", int'(q_m), 8'h3C);
        step("pop", 0, 0, 0, 1);

        // Gapped collection with D toggling while idle.
        send_gapped("gap_a5", 8'hA5);
        cmp("gap_a5.q_lsb", int'(q_l), 8'hA5);
        step("pop", 0, 0, 0, 1);
        send_gapped("gap_80", 8'h80);
        cmp("gap_80.q_lsb", int'(q_l), 8'h01);
        cmp("gap_80.q_msb", int'(q_m), 8'h80);
        step("pop", 0, 0, 0, 1);

        // Completion on the same edge as a pop replaces the held word.
        send_word("b2b", 8'h11, 1'b0);
        send_word("b2b", 8'h22, 1'b1);
        cmp("b2b.q",     int'(q_m),     8'h22);
        cmp("b2b.valid", int'(valid_m), 1);
        cmp("b2b.ovr",   int'(ovr_m),   0);
        step("pop", 0, 0, 0, 1);

        // Dropped word sets sticky Overrun; only Clear removes it.
        send_word("ovr", 8'h11, 1'b0);
        send_word("ovr", 8'h33, 1'b0);
        cmp("ovr.q",   int'(q_m),   8'h11);
        cmp("ovr.set", int'(ovr_m), 1);
        step("ovr_pop", 0, 0, 0, 1);
        cmp("ovr_pop.valid", int'(valid_m), 0);
        cmp("ovr_pop.ovr",   int'(ovr_m),   1);
        step("ovr_clr", 0, 0, 1, 0);
        cmp("ovr_clr.ovr", int'(ovr_m), 0);

        // Clear mid-word with E=1, D=1 while a word is held.
        send_word("clr", 8'h44, 1'b0);
        for (int i = 0; i < 5; i++) step("clr", 1, 1, 0, 0);
        step("clr_edge", 1, 1, 1, 0);
        cmp("clr_edge.cnt",   int'(cnt_m),   0);
        cmp("clr_edge.q",     int'(q_m),     8'h44);
        cmp("clr_edge.valid", int'(valid_m), 1);
        send_word("clr_next", 8'h5A, 1'b1);
        cmp("clr_next.q", int'(q_m), 8'h5A);
        step("clr_pop", 1, 0, 1, 1);
        cmp("clr_pop.valid", int'(valid_m), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r_e = ($urandom_range(0, 9) < 7);
            r_d = $urandom_range(0, 1);
            r_c = ($urandom_range(0, 99) < 3);
            r_r = ($urandom_range(0, 9) < 3);
            step("rand", r_e, r_d, r_c, r_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
